// File: rtl/ds_ldst_unit_if.sv
// ds_ldst_unit_if: memory-side port of the DS-form load/store unit.
//
// Handshake: memReq is the request valid. While memReq is high, memWrite,
// memSize, memAddr and memWData are stable, and memReq stays high until a
// rising edge on which memReady is also high. That edge completes the
// request, and memReq drops in the following cycle. memRspValid is a
// single-cycle data strobe with no back-pressure. It carries load data on
// memRData and is only meaningful while a load is waiting for it.
// memRData uses big-endian bit numbering: architectural bit 0 (the MSB) is
// memRData[addrWidth-1], and the low word [32:63] is memRData[31:0].
//
// Signals:
//   memReq       request valid            (master -> slave)
//   memReady     request accepted         (slave  -> master)
//   memWrite     1 = store                (master -> slave)
//   memSize      0 = word, 1 = doubleword (master -> slave)
//   memAddr      effective address        (master -> slave)
//   memWData     store data               (master -> slave)
//   memRspValid  load data valid          (slave  -> master)
//   memRData     load data                (slave  -> master)
interface ds_ldst_unit_if #(
    parameter int addrWidth = 64
);
    logic                 memReq;
    logic                 memReady;
    logic                 memWrite;
    logic                 memSize;
    logic [addrWidth-1:0] memAddr;
    logic [addrWidth-1:0] memWData;
    logic                 memRspValid;
    logic [addrWidth-1:0] memRData;

    modport master (
        output memReq, memWrite, memSize, memAddr, memWData,
        input  memReady, memRspValid, memRData
    );

    modport slave (
        input  memReq, memWrite, memSize, memAddr, memWData,
        output memReady, memRspValid, memRData
    );
endinterface

// File: rtl/ds_ldst_unit.sv
// ds_ldst_unit: executes Integer DS-form loads and stores (LD, LDU, LWA,
// STD, STDU). It reads the GPRs, forms the effective address, runs a single
// memory transaction, and then writes back RT and/or the updated RA.
//
// Ports:
//   clock_i, reset_i          clock; asynchronous active-low reset
//   enable_i, functionalUnitCode_i, op_i, reg1_i, reg2_i,
//   reg2ValOrZero_i, imm_i    decoded op from the DS-format decoder
//   stall_o                   high whenever the unit is busy
//   illegal_o                 one-cycle pulse when an op is rejected
//   rfAddrA_o/rfAddrB_o       GPR read indices (RA, RS/RT)
//   rfDataA_i/rfDataB_i       GPR read data, one cycle after the address
//   mem                       memory request/response port
//   wbValid_o/wbAddr_o/wbData_o  GPR write-back
//   dbgState_o                current FSM state
module ds_ldst_unit #(
    parameter int          addrWidth    = 64,
    parameter int          regWidth     = 5,
    parameter int          immWidth     = 14,
    parameter logic [1:0]  LdStUnitCode = 2'b01
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [1:0]           functionalUnitCode_i,
    input  logic [2:0]           op_i,
    input  logic [regWidth-1:0]  reg1_i,
    input  logic [regWidth-1:0]  reg2_i,
    input  logic                 reg2ValOrZero_i,
    input  logic [immWidth-1:0]  imm_i,
    output logic                 stall_o,
    output logic                 illegal_o,
    output logic [regWidth-1:0]  rfAddrA_o,
    output logic [regWidth-1:0]  rfAddrB_o,
    input  logic [addrWidth-1:0] rfDataA_i,
    input  logic [addrWidth-1:0] rfDataB_i,
    ds_ldst_unit_if.master       mem,
    output logic                 wbValid_o,
    output logic [regWidth-1:0]  wbAddr_o,
    output logic [addrWidth-1:0] wbData_o,
    output logic [2:0]           dbgState_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RDREG   = 3'd1,
        REQ     = 3'd2,
        WAITRSP = 3'd3,
        WB_RT   = 3'd4,
        WB_RA   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_LDU  = 3'd1;
    localparam logic [2:0] OP_LWA  = 3'd2;
    localparam logic [2:0] OP_STD  = 3'd3;
    localparam logic [2:0] OP_STDU = 3'd4;

    state_t                state_q, state_d;
    logic [2:0]            op_q;
    logic [regWidth-1:0]   rt_q, ra_q;
    logic                  zero_q;
    logic [immWidth-1:0]   imm_q;
    logic [addrWidth-1:0]  ea_q, wdata_q, ldata_q;
    logic                  size_q, illegal_q;

    logic                  accept, bad_op, is_load_q;
    logic [addrWidth-1:0]  base, disp;

    assign accept = (state_q == IDLE) && enable_i && (functionalUnitCode_i == LdStUnitCode);

    // Update forms need a real RA to write back. LDU with RA == RT would
    // make both write-backs target the same register.
    assign bad_op = (op_i > OP_STDU)
                 || (((op_i == OP_LDU) || (op_i == OP_STDU)) && (reg2_i == '0))
                 || ((op_i == OP_LDU) && (reg2_i == reg1_i));

    assign is_load_q = (op_q <= OP_LWA);

    // DS displacement: the immediate is a word offset, so append two zero
    // bits and sign-extend to the full address width.
    assign disp = {{(addrWidth-immWidth-2){imm_q[immWidth-1]}}, imm_q, 2'b00};
    assign base = (zero_q && (ra_q == '0)) ? '0 : rfDataA_i;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !bad_op) state_d = RDREG;
            RDREG:   state_d = REQ;
            REQ: begin
                if (mem.memReady) begin
                    if (is_load_q)              state_d = WAITRSP;
                    else if (op_q == OP_STDU)   state_d = WB_RA;
                    else                        state_d = IDLE;
                end
            end
            WAITRSP: if (mem.memRspValid) state_d = WB_RT;
            WB_RT:   state_d = (op_q == OP_LDU) ? WB_RA : IDLE;
            WB_RA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            op_q      <= '0;
            rt_q      <= '0;
            ra_q      <= '0;
            zero_q    <= 1'b0;
            imm_q     <= '0;
            ea_q      <= '0;
            wdata_q   <= '0;
            ldata_q   <= '0;
            size_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && bad_op;
            if (accept && !bad_op) begin
                op_q   <= op_i;
                rt_q   <= reg1_i;
                ra_q   <= reg2_i;
                zero_q <= reg2ValOrZero_i;
                imm_q  <= imm_i;
            end
            if (state_q == RDREG) begin
                ea_q    <= base + disp;
                wdata_q <= rfDataB_i;
                size_q  <= (op_q != OP_LWA);
            end
            if ((state_q == WAITRSP) && mem.memRspValid) begin
                // LWA sign-extends the low word, which is big-endian bits 32..63.
                ldata_q <= (op_q == OP_LWA)
                         ? {{(addrWidth-32){mem.memRData[31]}}, mem.memRData[31:0]}
                         : mem.memRData;
            end
        end
    end

    // The register file reads synchronously, so the indices go out in the
    // accept cycle and the data is available in RDREG.
    assign rfAddrA_o = accept ? reg2_i : '0;
    assign rfAddrB_o = accept ? reg1_i : '0;

    assign stall_o    = (state_q != IDLE);
    assign illegal_o  = illegal_q;
    assign dbgState_o = state_q;

    assign mem.memReq   = (state_q == REQ);
    assign mem.memWrite = (state_q == REQ) && !is_load_q;
    assign mem.memSize  = size_q;
    assign mem.memAddr  = ea_q;
    assign mem.memWData = wdata_q;

    assign wbValid_o = (state_q == WB_RT) || (state_q == WB_RA);
    assign wbAddr_o  = (state_q == WB_RT) ? rt_q    : (state_q == WB_RA) ? ra_q : '0;
    assign wbData_o  = (state_q == WB_RT) ? ldata_q : (state_q == WB_RA) ? ea_q : '0;
endmodule
